alpaca_cx_mac: RTL and testbench



---
 rtl/alpaca_cx_mac_if.sv | 44 ++++
 rtl/alpaca_cx_mac.sv | 245 ++++++++++++++++++++++++
 tb/tb_alpaca_cx_mac.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alpaca_cx_mac_if.sv
// rtl/alpaca_cx_mac_if.sv - beat/result bundle for the alpaca_cx_mac complex MAC
//
// Purpose: carries one input beat (qualifiers plus operands a, b, c) towards the
// MAC and the accumulated result back out.
// Ports (signals):
//   din_valid, din_first, din_last, conj   beat qualifiers
//   a_re, a_im, c_re, c_im                 WIDTH-bit signed operands
//   b_re, b_im                             PHASE_WIDTH-bit signed operand
//   dout_valid, dout_re, dout_im, ovf      ACC_W-bit result and its strobe/flag
// Modports: master drives beats and observes results; slave is the MAC.
interface alpaca_cx_mac_if #(
    parameter int WIDTH       = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int ACC_GUARD   = 4
);
    localparam int ACC_W = WIDTH + PHASE_WIDTH + 1 + ACC_GUARD;

    logic                          din_valid;
    logic                          din_first;
    logic                          din_last;
    logic                          conj;
    logic signed [WIDTH-1:0]       a_re;
    logic signed [WIDTH-1:0]       a_im;
    logic signed [PHASE_WIDTH-1:0] b_re;
    logic signed [PHASE_WIDTH-1:0] b_im;
    logic signed [WIDTH-1:0]       c_re;
    logic signed [WIDTH-1:0]       c_im;
    logic                          dout_valid;
    logic signed [ACC_W-1:0]       dout_re;
    logic signed [ACC_W-1:0]       dout_im;
    logic                          ovf;

    modport master (
        output din_valid, din_first, din_last, conj,
        output a_re, a_im, b_re, b_im, c_re, c_im,
        input  dout_valid, dout_re, dout_im, ovf
    );

    modport slave (
        input  din_valid, din_first, din_last, conj,
        input  a_re, a_im, b_re, b_im, c_re, c_im,
        output dout_valid, dout_re, dout_im, ovf
    );
endinterface

// File: rtl/alpaca_cx_mac.sv
// rtl/alpaca_cx_mac.sv - pipelined complex multiply-accumulate with framed groups
//
// Purpose: computes a*b (or a*conj(b)) per valid beat and accumulates it over a
// group opened by din_first (seeded with c << PHASE_FRAC_WIDTH) and closed by
// din_last. first&last on one beat is a single multiply-add. Two's complement,
// wrap at ACC_W, no rounding.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alpaca_cx_mac_if.slave (din_* qualifiers, a/b/c operands in;
//        dout_valid, dout_re/dout_im, ovf out)
// Timing: seven register stages; a beat sampled at edge N is loaded into the
// output register at edge N+6, so the consumer samples dout_valid=1 at edge N+7.
// Optional feature macro: CX_MAC_OVF_EN builds the sticky per-group overflow
// detector; without it ovf is tied to 0 and the latency is unchanged.
module alpaca_cx_mac #(
    parameter int WIDTH            = 16,
    parameter int FRAC_WIDTH       = 15,
    parameter int PHASE_WIDTH      = 16,
    parameter int PHASE_FRAC_WIDTH = 15,
    parameter int ACC_GUARD        = 4
) (
    input  logic           clk,
    input  logic           rst,
    alpaca_cx_mac_if.slave bus
);
    localparam int ACC_W  = WIDTH + PHASE_WIDTH + 1 + ACC_GUARD;
    localparam int PROD_W = WIDTH + PHASE_WIDTH;

    // control vector bit positions: {valid, first, last, conj}
    localparam int CV = 3;
    localparam int CF = 2;
    localparam int CL = 1;
    localparam int CC = 0;

    if (FRAC_WIDTH >= WIDTH || PHASE_FRAC_WIDTH >= PHASE_WIDTH) begin : g_frac_check
        $error("alpaca_cx_mac: fractional widths must leave a sign bit");
    end

    // ---------------- stage 1: input register ----------------
    logic [3:0]                    ctl1;
    logic signed [WIDTH-1:0]       ar1, ai1, cr1, ci1;
    logic signed [PHASE_WIDTH-1:0] br1, bi1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl1 <= '0;
            ar1  <= '0;
            ai1  <= '0;
            br1  <= '0;
            bi1  <= '0;
            cr1  <= '0;
            ci1  <= '0;
        end else begin
            ctl1 <= {bus.din_valid, bus.din_first, bus.din_last, bus.conj};
            ar1  <= bus.a_re;
            ai1  <= bus.a_im;
            br1  <= bus.b_re;
            bi1  <= bus.b_im;
            cr1  <= bus.c_re;
            ci1  <= bus.c_im;
        end
    end

    // ---------------- stages 2-3: partial products, two DSP registers ----------------
    logic [3:0]               ctl2, ctl3;
    logic signed [PROD_W-1:0] p_rr2, p_ii2, p_ir2, p_ri2;
    logic signed [PROD_W-1:0] p_rr3, p_ii3, p_ir3, p_ri3;
    logic signed [WIDTH-1:0]  cr2, ci2, cr3, ci3;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl2  <= '0;
            ctl3  <= '0;
            p_rr2 <= '0;
            p_ii2 <= '0;
            p_ir2 <= '0;
            p_ri2 <= '0;
            p_rr3 <= '0;
            p_ii3 <= '0;
            p_ir3 <= '0;
            p_ri3 <= '0;
            cr2   <= '0;
            ci2   <= '0;
            cr3   <= '0;
            ci3   <= '0;
        end else begin
            ctl2  <= ctl1;
            // operands widened first so each product keeps full precision
            p_rr2 <= PROD_W'(ar1) * PROD_W'(br1);
            p_ii2 <= PROD_W'(ai1) * PROD_W'(bi1);
            p_ir2 <= PROD_W'(ai1) * PROD_W'(br1);
            p_ri2 <= PROD_W'(ar1) * PROD_W'(bi1);
            cr2   <= cr1;
            ci2   <= ci1;
            ctl3  <= ctl2;
            p_rr3 <= p_rr2;
            p_ii3 <= p_ii2;
            p_ir3 <= p_ir2;
            p_ri3 <= p_ri2;
            cr3   <= cr2;
            ci3   <= ci2;
        end
    end

    // ---------------- stage 4: cross add/sub and c alignment ----------------
    logic signed [ACC_W-1:0] x_rr, x_ii, x_ir, x_ri, x_re, x_im;

    always_comb begin
        x_rr = ACC_W'(p_rr3);
        x_ii = ACC_W'(p_ii3);
        x_ir = ACC_W'(p_ir3);
        x_ri = ACC_W'(p_ri3);
        // conj(b) flips the sign of b_im, i.e. the ai*bi and ar*bi terms
        x_re = ctl3[CC] ? x_rr + x_ii : x_rr - x_ii;
        x_im = ctl3[CC] ? x_ir - x_ri : x_ir + x_ri;
    end

    logic [CV:CL]            ctl4;
    logic signed [ACC_W-1:0] s_re4, s_im4, c_re4, c_im4;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl4  <= '0;
            s_re4 <= '0;
            s_im4 <= '0;
            c_re4 <= '0;
            c_im4 <= '0;
        end else begin
            ctl4  <= ctl3[CV:CL];
            s_re4 <= x_re;
            s_im4 <= x_im;
            c_re4 <= ACC_W'(cr3) <<< PHASE_FRAC_WIDTH;
            c_im4 <= ACC_W'(ci3) <<< PHASE_FRAC_WIDTH;
        end
    end

    // ---------------- stage 5: group FSM and accumulator ----------------
    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] base_re, base_im, add_re, add_im;
    logic                    take, emit_nxt, emit5;

    // a first beat always reseeds from c, dropping any open partial group
    assign base_re = ctl4[CF] ? c_re4 : acc_re;
    assign base_im = ctl4[CF] ? c_im4 : acc_im;
    assign add_re  = base_re + s_re4;
    assign add_im  = base_im + s_im4;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        emit_nxt  = 1'b0;
        if (ctl4[CV] && (ctl4[CF] || state == S_ACCUM)) begin
            take      = 1'b1;
            emit_nxt  = ctl4[CL];
            state_nxt = ctl4[CL] ? S_IDLE : S_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            acc_re <= '0;
            acc_im <= '0;
            emit5  <= 1'b0;
        end else begin
            state <= state_nxt;
            emit5 <= emit_nxt;
            if (take) begin
                acc_re <= add_re;
                acc_im <= add_im;
            end
        end
    end

    // ---------------- stages 6-7: overflow stage and output register ----------------
    logic                    v6, dv_q;
    logic signed [ACC_W-1:0] re6, im6, dre_q, dim_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v6    <= 1'b0;
            re6   <= '0;
            im6   <= '0;
            dv_q  <= 1'b0;
            dre_q <= '0;
            dim_q <= '0;
        end else begin
            v6   <= emit5;
            re6  <= acc_re;
            im6  <= acc_im;
            dv_q <= v6;
            if (v6) begin
                dre_q <= re6;
                dim_q <= im6;
            end
        end
    end

    assign bus.dout_valid = dv_q;
    assign bus.dout_re    = dre_q;
    assign bus.dout_im    = dim_q;

`ifdef CX_MAC_OVF_EN
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a, b, s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [ACC_W-1:0] a, b, s);
        return (a[ACC_W-1] != b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    logic x_ovf, a_ovf, ovf4, ovf_grp, ovf6, ovf_q;

    always_comb begin
        x_ovf = ctl3[CC] ? (add_ovf(x_rr, x_ii, x_re) | sub_ovf(x_ir, x_ri, x_im))
                         : (sub_ovf(x_rr, x_ii, x_re) | add_ovf(x_ir, x_ri, x_im));
        a_ovf = add_ovf(base_re, s_re4, add_re) | add_ovf(base_im, s_im4, add_im);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf4    <= 1'b0;
            ovf_grp <= 1'b0;
            ovf6    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf4 <= x_ovf;
            // sticky over the group; a first beat starts from a clean flag
            if (take) begin
                ovf_grp <= (ctl4[CF] ? 1'b0 : ovf_grp) | ovf4 | a_ovf;
            end
            ovf6  <= emit5 & ovf_grp;
            ovf_q <= v6 & ovf6;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alpaca_cx_mac.sv
// tb/tb_alpaca_cx_mac.sv - self-checking bench for alpaca_cx_mac
`timescale 1ns/1ps
module tb_alpaca_cx_mac;
    localparam int WIDTH            = 16;
    localparam int FRAC_WIDTH       = 15;
    localparam int PHASE_WIDTH      = 16;
    localparam int PHASE_FRAC_WIDTH = 15;
    localparam int ACC_GUARD        = 4;
    localparam int ACC_W            = WIDTH + PHASE_WIDTH + 1 + ACC_GUARD;
    localparam int LAT              = 7;

`ifdef CX_MAC_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alpaca_cx_mac_if #(.WIDTH(WIDTH), .PHASE_WIDTH(PHASE_WIDTH), .ACC_GUARD(ACC_GUARD)) bus ();

    alpaca_cx_mac #(
        .WIDTH(WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .PHASE_WIDTH(PHASE_WIDTH),
        .PHASE_FRAC_WIDTH(PHASE_FRAC_WIDTH), .ACC_GUARD(ACC_GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        longint due;
        longint re;
        longint im;
        bit     ovf;
    } exp_t;

    exp_t   expq[$];
    longint edge_n  = 0;
    bit     rst_hit = 1'b0;
    bit     m_open  = 1'b0;
    bit     m_ovf   = 1'b0;
    longint m_re    = 0;
    longint m_im    = 0;
    longint last_re = 0;
    longint last_im = 0;

    function automatic longint wrap(input longint x);
        logic signed [ACC_W-1:0] t;
        t = x[ACC_W-1:0];
        return longint'(t);
    endfunction

    function automatic bit fits(input longint x);
        longint lim;
        lim = longint'(1) <<< (ACC_W - 1);
        return (x >= -lim) && (x < lim);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference: exact complex arithmetic per beat, group bookkeeping, wrap at ACC_W.
    task automatic model_beat();
        longint ar, ai, br, bi, pre, pim, s, scale;
        bit     o, take;
        exp_t   e;
        ar    = longint'(bus.a_re);
        ai    = longint'(bus.a_im);
        br    = longint'(bus.b_re);
        bi    = longint'(bus.b_im);
        scale = longint'(1) << PHASE_FRAC_WIDTH;
        pre   = bus.conj ? ar * br + ai * bi : ar * br - ai * bi;
        pim   = bus.conj ? ai * br - ar * bi : ai * br + ar * bi;
        o     = !fits(pre) || !fits(pim);
        take  = 1'b1;
        if (bus.din_first) begin
            s = longint'(bus.c_re) * scale + pre; o |= !fits(s); m_re = wrap(s);
            s = longint'(bus.c_im) * scale + pim; o |= !fits(s); m_im = wrap(s);
            m_ovf  = o;
            m_open = 1'b1;
        end else if (m_open) begin
            s = m_re + pre; o |= !fits(s); m_re = wrap(s);
            s = m_im + pim; o |= !fits(s); m_im = wrap(s);
            m_ovf = m_ovf | o;
        end else begin
            take = 1'b0;
        end
        if (take && bus.din_last) begin
            e.due = edge_n + LAT - 1;
            e.re  = m_re;
            e.im  = m_im;
            e.ovf = m_ovf;
            expq.push_back(e);
            m_open = 1'b0;
        end
    endtask

    task automatic check_cycle();
        bit   ev;
        exp_t e;
        if (rst_hit) begin
            last_re = 0;
            last_im = 0;
            rst_hit = 1'b0;
        end
        ev = (expq.size() > 0) && (expq[0].due == edge_n);
        chk("dout_valid", 64'(bus.dout_valid), 64'(ev));
        if (ev) begin
            e       = expq.pop_front();
            last_re = e.re;
            last_im = e.im;
            chk("dout_re", 64'(bus.dout_re), e.re);
            chk("dout_im", 64'(bus.dout_im), e.im);
            chk("ovf", 64'(bus.ovf), 64'(OVF_ON & e.ovf));
        end else begin
            chk("dout_re_hold", 64'(bus.dout_re), last_re);
            chk("dout_im_hold", 64'(bus.dout_im), last_im);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (rst) begin
            expq.delete();
            m_open  = 1'b0;
            m_ovf   = 1'b0;
            rst_hit = 1'b1;
        end else if (bus.din_valid) begin
            model_beat();
        end
        #1;
        check_cycle();
    endtask

    task automatic beat(input bit v, f, l, cj, input int ar, ai, br, bi, cr, ci);
        bus.din_valid = v;
        bus.din_first = f;
        bus.din_last  = l;
        bus.conj      = cj;
        bus.a_re      = WIDTH'(ar);
        bus.a_im      = WIDTH'(ai);
        bus.b_re      = PHASE_WIDTH'(br);
        bus.b_im      = PHASE_WIDTH'(bi);
        bus.c_re      = WIDTH'(cr);
        bus.c_im      = WIDTH'(ci);
        tick();
    endtask

    task automatic idle(input int n);
        bus.din_valid = 1'b0;
        bus.din_first = 1'b0;
        bus.din_last  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        bus.din_valid = 1'b0; bus.din_first = 1'b0; bus.din_last = 1'b0; bus.conj = 1'b0;
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0; bus.c_re = '0; bus.c_im = '0;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_valid", 64'(bus.dout_valid), 0);
        chk("reset_re", 64'(bus.dout_re), 0);
        chk("reset_im", 64'(bus.dout_im), 0);
        chk("reset_ovf", 64'(bus.ovf), 0);
        rst = 1'b0;

        // single multiply-add, exact latency
        beat(1, 1, 1, 0, 1, 1, 1, 1, 1, 1);
        idle(5);
        chk("single_early", 64'(bus.dout_valid), 0);
        idle(1);
        chk("single_valid", 64'(bus.dout_valid), 1);
        chk("single_re", 64'(bus.dout_re), 32768);
        chk("single_im", 64'(bus.dout_im), 32770);
        chk("single_ovf", 64'(bus.ovf), 0);

        // conjugate
        beat(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        idle(6);
        chk("conj_re", 64'(bus.dout_re), 32770);
        chk("conj_im", 64'(bus.dout_im), 32768);

        // group of 4
        beat(1, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        beat(1, 0, 0, 0, 1, 1, 1, 1, 0, 0);
        beat(1, 0, 0, 0, 1, 1, 1, 1, 0, 0);
        beat(1, 0, 1, 0, 1, 1, 1, 1, 0, 0);
        idle(5);
        chk("group4_early", 64'(bus.dout_valid), 0);
        idle(1);
        chk("group4_valid", 64'(bus.dout_valid), 1);
        chk("group4_re", 64'(bus.dout_re), 0);
        chk("group4_im", 64'(bus.dout_im), 8);

        // back-to-back 2-beat groups
        beat(1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        beat(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        beat(1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        beat(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        idle(4);
        chk("b2b_first_valid", 64'(bus.dout_valid), 1);
        chk("b2b_first_re", 64'(bus.dout_re), 2);
        idle(1);
        chk("b2b_gap", 64'(bus.dout_valid), 0);
        idle(1);
        chk("b2b_second_valid", 64'(bus.dout_valid), 1);
        chk("b2b_second_im", 64'(bus.dout_im), 2);

        // drop while idle, then restart inside an open group
        beat(1, 0, 1, 0, 3, 3, 1, 0, 0, 0);
        beat(1, 1, 0, 0, 1, 1, 1, 0, 5, 0);
        beat(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        beat(1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        beat(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        beat(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        idle(6);
        chk("restart_re", 64'(bus.dout_re), 3);
        idle(2);

        // 40-beat overflow group
        beat(1, 1, 0, 0, -32768, -32768, -32768, -32768, 0, 0);
        repeat (38) beat(1, 0, 0, 0, -32768, -32768, -32768, -32768, 0, 0);
        beat(1, 0, 1, 0, -32768, -32768, -32768, -32768, 0, 0);
        idle(6);
        chk("ovf_valid", 64'(bus.dout_valid), 1);
        chk("ovf_re", 64'(bus.dout_re), 0);
        chk("ovf_im", 64'(bus.dout_im), -64'sd51539607552);
        chk("ovf_flag", 64'(bus.ovf), 64'(OVF_ON));

        // reset with a result in flight and a group open
        beat(1, 1, 1, 0, 7, -2, 3, 4, 1, 1);
        idle(2);
        beat(1, 1, 0, 0, 2, 2, 2, 2, 0, 0);
        beat(1, 0, 0, 0, 2, 2, 2, 2, 0, 0);
        bus.din_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        beat(1, 0, 1, 0, 2, 2, 2, 2, 0, 0);
        idle(8);
        chk("rst_quiet_valid", 64'(bus.dout_valid), 0);
        chk("rst_quiet_re", 64'(bus.dout_re), 0);
        beat(1, 1, 1, 0, 2, 0, 3, 0, 0, 0);
        idle(6);
        chk("post_rst_valid", 64'(bus.dout_valid), 1);
        chk("post_rst_re", 64'(bus.dout_re), 6);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            bus.din_valid = ($urandom_range(3) != 0);
            bus.din_first = ($urandom_range(4) == 0);
            bus.din_last  = ($urandom_range(3) == 0);
            bus.conj      = $urandom_range(1);
            bus.a_re      = WIDTH'($urandom);
            bus.a_im      = WIDTH'($urandom);
            bus.b_re      = PHASE_WIDTH'($urandom);
            bus.b_im      = PHASE_WIDTH'($urandom);
            bus.c_re      = WIDTH'($urandom);
            bus.c_im      = WIDTH'($urandom);
            if ($urandom_range(9) == 0) begin
                bus.a_re = {1'b1, {(WIDTH-1){1'b0}}};
                bus.b_im = {1'b1, {(PHASE_WIDTH-1){1'b0}}};
            end
            rst = ($urandom_range(249) == 0);
            tick();
        end
        rst = 1'b0;
        idle(10);
        chk("queue_drained", 64'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
